frame_scanner: RTL and testbench

Frame-sweep controller and display-source arbiter for the 320×240, 1-bit display path. On each frame request it hands the screen to one owner, the menu or the active game, and sweeps every pixel coordinate into that owner. It then collects the owner's registered colour after a fixed pipeline latency and issues one framebuffer write per pixel to the VGA adapter. Ownership is decided once per frame from `GameChoice`, so a source never sees its coordinate stream switch mid-frame.

---
 rtl/frame_scan_pkg.sv | 39 +++
 rtl/frame_scanner_if.sv | 30 +++
 rtl/scan_delay_line.sv | 27 ++
 rtl/frame_scanner.sv | 164 ++++++++++++++++
 tb/tb_frame_scanner.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/frame_scan_pkg.sv
// Shared types and constants for the frame_scanner display sweep.
package frame_scan_pkg;

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned CW = 4;

  localparam int unsigned DEF_H_RES    = 320;
  localparam int unsigned DEF_V_RES    = 240;
  localparam int unsigned DEF_PIPE_LAT = 3;

  localparam logic [CW-1:0] CHOICE_SPLASH = 4'b0000;
  localparam logic [CW-1:0] CHOICE_MENU   = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_e;

  typedef enum logic {
    OWNER_MENU,
    OWNER_GAME
  } owner_e;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  // Splash and menu screens are both drawn by the menu source.
  function automatic owner_e owner_of(input logic [CW-1:0] choice);
    return (choice == CHOICE_SPLASH || choice == CHOICE_MENU) ? OWNER_MENU : OWNER_GAME;
  endfunction

endpackage

// File: rtl/frame_scanner_if.sv
// Source/framebuffer side bundle of the frame_scanner.
interface frame_scanner_if;
  import frame_scan_pkg::*;

  logic          FrameTick;
  logic [CW-1:0] GameChoice;
  logic          MenuCol;
  logic          GameCol;
  logic [XW-1:0] VGAx;
  logic [YW-1:0] VGAy;
  logic          MenuEnable;
  logic          GameEnable;
  logic [XW-1:0] WrX;
  logic [YW-1:0] WrY;
  logic          WrCol;
  logic          WrEn;
  logic          Busy;
  logic          FrameDone;

  modport master (
    output FrameTick, GameChoice, MenuCol, GameCol,
    input  VGAx, VGAy, MenuEnable, GameEnable, WrX, WrY, WrCol, WrEn, Busy, FrameDone
  );

  modport slave (
    input  FrameTick, GameChoice, MenuCol, GameCol,
    output VGAx, VGAy, MenuEnable, GameEnable, WrX, WrY, WrCol, WrEn, Busy, FrameDone
  );

endinterface

// File: rtl/scan_delay_line.sv
// Fixed-depth shift register aligning sweep coordinates with source colour.
module scan_delay_line
  import frame_scan_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  pix_t din,
  output pix_t dout
);

  pix_t stage [DEPTH];

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/frame_scanner.sv
// Frame sweep controller and menu/game display arbiter.
// Optional pre-scan clear pass enabled by defining FRAME_SCANNER_CLEAR_EN.
module frame_scanner
  import frame_scan_pkg::*;
#(
  parameter int unsigned H_RES    = DEF_H_RES,
  parameter int unsigned V_RES    = DEF_V_RES,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input logic            Clock,
  input logic            Reset,
  frame_scanner_if.slave bus
);

  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

`ifdef FRAME_SCANNER_CLEAR_EN
  localparam scan_state_e FIRST_ST = ST_CLEAR;
`else
  localparam scan_state_e FIRST_ST = ST_SCAN;
`endif

  scan_state_e   state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          pending_q, pending_d;
  logic          start;
  logic          x_last, y_last, in_frame;

  logic busy_q, menu_en_q, game_en_q, done_q;
  pix_t scan_q, dl_q, clr_q;

  assign x_last   = (x_q == XW'(H_RES - 1));
  assign y_last   = (y_q == YW'(V_RES - 1));
  assign in_frame = (state_q == ST_CLEAR) || (state_q == ST_SCAN) || (state_q == ST_DRAIN);

  // FSM and sweep counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_MENU;
      x_q       <= '0;
      y_q       <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      x_q       <= x_d;
      y_q       <= y_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
    end
  end

  // Next state; owner is latched only at frame start.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    x_d       = x_q;
    y_d       = y_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.FrameTick || pending_q) start = 1'b1;
      end
      ST_CLEAR, ST_SCAN: begin
        if (bus.FrameTick) pending_d = 1'b1;
        if (x_last) begin
          x_d = '0;
          if (y_last) begin
            y_d     = '0;
            state_d = (state_q == ST_CLEAR) ? ST_SCAN : ST_DRAIN;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.FrameTick) pending_d = 1'b1;
        if (drain_q == DW'(PIPE_LAT - 1)) begin
          drain_d = '0;
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: begin
        if (bus.FrameTick || pending_q) start = 1'b1;
        else                            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      owner_d   = owner_of(bus.GameChoice);
      pending_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      drain_d   = '0;
      state_d   = FIRST_ST;
    end
  end

  // Registered status and sweep coordinate outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q    <= 1'b0;
      menu_en_q <= 1'b0;
      game_en_q <= 1'b0;
      done_q    <= 1'b0;
      scan_q    <= '0;
    end else begin
      busy_q       <= in_frame;
      menu_en_q    <= in_frame && (owner_q == OWNER_MENU);
      game_en_q    <= in_frame && (owner_q == OWNER_GAME);
      done_q       <= (state_q == ST_DONE);
      scan_q.valid <= (state_q == ST_SCAN);
      scan_q.x     <= (state_q == ST_SCAN) ? x_q : '0;
      scan_q.y     <= (state_q == ST_SCAN) ? y_q : '0;
    end
  end

`ifdef FRAME_SCANNER_CLEAR_EN
  // Direct colour-0 writes during the clear pass, bypassing the delay line.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clr_q <= '0;
    end else begin
      clr_q.valid <= (state_q == ST_CLEAR);
      clr_q.x     <= (state_q == ST_CLEAR) ? x_q : '0;
      clr_q.y     <= (state_q == ST_CLEAR) ? y_q : '0;
    end
  end
`else
  assign clr_q = '0;
`endif

  scan_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk  (Clock),
    .rst  (Reset),
    .din  (scan_q),
    .dout (dl_q)
  );

  assign bus.VGAx       = scan_q.x;
  assign bus.VGAy       = scan_q.y;
  assign bus.Busy       = busy_q;
  assign bus.MenuEnable = menu_en_q;
  assign bus.GameEnable = game_en_q;
  assign bus.FrameDone  = done_q;
  assign bus.WrEn       = dl_q.valid | clr_q.valid;
  assign bus.WrX        = dl_q.valid ? dl_q.x : clr_q.x;
  assign bus.WrY        = dl_q.valid ? dl_q.y : clr_q.y;
  assign bus.WrCol      = dl_q.valid & ((owner_q == OWNER_GAME) ? bus.GameCol : bus.MenuCol);

endmodule

// File: tb/tb_frame_scanner.sv
// Directed bench for frame_scanner on a reduced 8x4 raster.
module tb_frame_scanner;

  localparam int H   = 8;
  localparam int V   = 4;
  localparam int LAT = 3;
  localparam int P   = H * V;
`ifdef FRAME_SCANNER_CLEAR_EN
  localparam int SOFF      = P;
  localparam int EXP_FIRST = 0;
  localparam int EXP_NWR   = 2 * P;
`else
  localparam int SOFF      = 0;
  localparam int EXP_FIRST = LAT;
  localparam int EXP_NWR   = P;
`endif
  localparam int EXP_DONE = SOFF + P + LAT;
  localparam int MAX_C    = EXP_DONE + 20;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic menu_col;
  logic game_col;

  frame_scanner_if bus ();

  frame_scanner #(
    .H_RES    (H),
    .V_RES    (V),
    .PIPE_LAT (LAT)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once(input string tag);
    bus.FrameTick = 1'b1;
    step();
    bus.FrameTick = 1'b0;
    check({tag, "_lat"}, int'(bus.Busy), 0);
  endtask

  // Follow one frame from its first scan cycle to FrameDone.
  task automatic run_frame(input string tag, input bit exp_menu, input int chg_at,
                           input logic [3:0] chg_val, input int n_extra);
    int first_wr, done_c, n_wr, bad_wr, bad_xy, bad_en, si, wi, ex, ey, ec;
    first_wr = -1; done_c = -1; n_wr = 0; bad_wr = 0; bad_xy = 0; bad_en = 0;
    for (int c = 0; c < MAX_C; c++) begin
      step();
      if (bus.FrameDone) begin
        done_c = c;
        break;
      end
      if (!bus.Busy || bus.MenuEnable != exp_menu || bus.GameEnable != !exp_menu) bad_en++;
      si = c - SOFF;
      ex = (si >= 0 && si < P) ? si % H : 0;
      ey = (si >= 0 && si < P) ? si / H : 0;
      if (int'(bus.VGAx) != ex || int'(bus.VGAy) != ey) bad_xy++;
      if (bus.WrEn) begin
        if (first_wr < 0) first_wr = c;
        wi = (n_wr >= SOFF) ? n_wr - SOFF : n_wr;
        ec = (n_wr < SOFF) ? 0 : (exp_menu ? int'(menu_col) : int'(game_col));
        if (int'(bus.WrX) != wi % H || int'(bus.WrY) != wi / H || int'(bus.WrCol) != ec) bad_wr++;
        n_wr++;
      end
      bus.FrameTick = ((c == 5 && n_extra > 0) || (c == 7 && n_extra > 1) || (c == 9 && n_extra > 2));
      if (c == chg_at) bus.GameChoice = chg_val;
    end
    bus.FrameTick = 1'b0;
    check({tag, "_first_wr"}, first_wr, EXP_FIRST);
    check({tag, "_done_cycle"}, done_c, EXP_DONE);
    check({tag, "_n_writes"}, n_wr, EXP_NWR);
    check({tag, "_bad_writes"}, bad_wr, 0);
    check({tag, "_bad_xy"}, bad_xy, 0);
    check({tag, "_bad_enable"}, bad_en, 0);
    check({tag, "_done_idle"}, int'({bus.Busy, bus.MenuEnable, bus.GameEnable}), 0);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.FrameTick  = 1'b0;
    bus.GameChoice = 4'b0001;
    menu_col = 1'b0;
    game_col = 1'b0;
    bus.MenuCol = menu_col;
    bus.GameCol = game_col;
    step(); step(); step();
    check("rst_busy", int'(bus.Busy), 0);
    check("rst_wren", int'(bus.WrEn), 0);
    check("rst_done", int'(bus.FrameDone), 0);
    check("rst_enables", int'({bus.MenuEnable, bus.GameEnable}), 0);
    check("rst_xy", int'({bus.VGAx, bus.VGAy}), 0);
    rst = 1'b0;
    step();

    // Menu frame
    menu_col = 1'b1; game_col = 1'b0;
    bus.MenuCol = menu_col; bus.GameCol = game_col;
    bus.GameChoice = 4'b0001;
    tick_once("menu");
    run_frame("menu", 1'b1, -1, 4'b0000, 0);

    // Game frame with opposite colours
    step();
    menu_col = 1'b0; game_col = 1'b1;
    bus.MenuCol = menu_col; bus.GameCol = game_col;
    bus.GameChoice = 4'b0100;
    tick_once("game");
    run_frame("game", 1'b0, -1, 4'b0000, 0);

    // Choice changes mid-frame; owner holds, next frame follows new choice
    step();
    menu_col = 1'b1; game_col = 1'b0;
    bus.MenuCol = menu_col; bus.GameCol = game_col;
    bus.GameChoice = 4'b0001;
    tick_once("chg");
    run_frame("chg", 1'b1, 10, 4'b0010, 0);
    tick_once("chg_next");
    run_frame("chg_next", 1'b0, -1, 4'b0000, 0);

    // Three ticks while busy collapse into one back-to-back frame
    step();
    bus.GameChoice = 4'b0000;
    tick_once("pend");
    run_frame("pend", 1'b1, -1, 4'b0000, 3);
    run_frame("pend2", 1'b1, -1, 4'b0000, 0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      busy_cnt += int'(bus.Busy);
    end
    check("pend_no_third", busy_cnt, 0);

    // Reset in the middle of a game frame
    bus.GameChoice = 4'b0111;
    tick_once("rst_mid");
    for (int i = 0; i < 22; i++) step();
    check("pre_rst_busy", int'(bus.Busy), 1);
    check("pre_rst_wren", int'(bus.WrEn), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_wren", int'(bus.WrEn), 0);
    check("mid_rst_busy", int'(bus.Busy), 0);
    check("mid_rst_enables", int'({bus.MenuEnable, bus.GameEnable}), 0);
    check("mid_rst_xy", int'({bus.VGAx, bus.VGAy}), 0);
    step();
    rst = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      busy_cnt += int'(bus.Busy);
      done_cnt += int'(bus.FrameDone);
    end
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_done", done_cnt, 0);
    tick_once("rst_next");
    run_frame("rst_next", 1'b0, -1, 4'b0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
